// File: rtl/antares_cloz_scheduler_pkg.sv
// Shared constants for the CLO/CLZ scheduler: op encoding, FSM states, latched request.
package antares_cloz_scheduler_pkg;

  localparam logic OP_CLZ = 1'b0;
  localparam logic OP_CLO = 1'b1;

  localparam int CNT_W = 6;  // 0..32 from one 32-bit pass
  localparam int RES_W = 7;  // 0..64 after two passes

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVAL_HI = 2'd1,
    ST_EVAL_LO = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic        op;
    logic        wide;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        port;
  } req_s;

endpackage

// File: rtl/antares_cloz.sv
// 32-bit leading-zero and leading-one counter; both counts produced every cycle.
module antares_cloz
  import antares_cloz_scheduler_pkg::*;
(
  input  logic [31:0]      data_i,
  output logic [CNT_W-1:0] clz_result_o,
  output logic [CNT_W-1:0] clo_result_o
);

  // Ascending scan: the most significant set bit is the last to write.
  always_comb begin
    clz_result_o = 6'd32;
    clo_result_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i])  clz_result_o = 6'(31 - i);
      if (!data_i[i]) clo_result_o = 6'(31 - i);
    end
  end

endmodule

// File: rtl/antares_cloz_scheduler.sv
// Two-port scheduler sharing one CLO/CLZ unit; one or two passes per op, registered result.
module antares_cloz_scheduler
  import antares_cloz_scheduler_pkg::*;
#(
  parameter logic PRIO_FIXED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic             req0_wide,
  input  logic [31:0]      req0_hi,
  input  logic [31:0]      req0_lo,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic             req1_wide,
  input  logic [31:0]      req1_hi,
  input  logic [31:0]      req1_lo,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [RES_W-1:0] rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [RES_W-1:0] rsp1_result
);

  state_e           state_q, state_d;
  req_s             req_q, req_d;
  logic             last_q, last_d;
  logic [RES_W-1:0] res_q, res_d;

  logic             gnt0, gnt1, accept_en;
  logic [31:0]      operand;
  logic [CNT_W-1:0] clz_cnt, clo_cnt, cnt;

  // Port 1 wins a tie only when round-robin and port 0 went last.
  always_comb begin
    if (PRIO_FIXED)
      gnt1 = req1_valid & ~req0_valid;
    else if (req0_valid & req1_valid)
      gnt1 = ~last_q;
    else
      gnt1 = req1_valid & ~req0_valid;
    gnt0 = req0_valid & ~gnt1;
  end

  // rst_n gating keeps ready low for the whole reset window, not just after it.
  assign accept_en  = (state_q == ST_IDLE) & rst_n;
  assign req0_ready = accept_en & gnt0;
  assign req1_ready = accept_en & gnt1;

  assign operand = (state_q == ST_EVAL_HI && req_q.wide) ? req_q.hi : req_q.lo;

  antares_cloz u_cloz (
    .data_i       (operand),
    .clz_result_o (clz_cnt),
    .clo_result_o (clo_cnt)
  );

  assign cnt = (req_q.op == OP_CLO) ? clo_cnt : clz_cnt;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    last_d  = last_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_ready) begin
          req_d   = '{op: req0_op, wide: req0_wide, hi: req0_hi, lo: req0_lo, port: 1'b0};
          last_d  = 1'b0;
          state_d = ST_EVAL_HI;
        end else if (req1_ready) begin
          req_d   = '{op: req1_op, wide: req1_wide, hi: req1_hi, lo: req1_lo, port: 1'b1};
          last_d  = 1'b1;
          state_d = ST_EVAL_HI;
        end
      end
      ST_EVAL_HI: begin
        // A saturated upper word means the count continues into the lower word.
        if (req_q.wide && cnt == 6'd32) begin
          res_d   = 7'd32;
          state_d = ST_EVAL_LO;
        end else begin
          res_d   = {1'b0, cnt};
          state_d = ST_RESP;
        end
      end
      ST_EVAL_LO: begin
        res_d   = 7'd32 + {1'b0, cnt};
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (req_q.port ? rsp1_ready : rsp0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      last_q  <= 1'b1;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
      res_q   <= res_d;
    end
  end

  assign rsp0_valid  = (state_q == ST_RESP) & ~req_q.port;
  assign rsp1_valid  = (state_q == ST_RESP) &  req_q.port;
  assign rsp0_result = rsp0_valid ? res_q : '0;
  assign rsp1_result = rsp1_valid ? res_q : '0;

endmodule

// File: tb/tb_antares_cloz_scheduler.sv
// Directed bench: single-op vector table, arbitration, back-pressure and mid-op reset sequences.
module tb_antares_cloz_scheduler;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_op, req0_wide;
  logic [31:0] req0_hi, req0_lo;
  logic        req1_valid, req1_ready, req1_op, req1_wide;
  logic [31:0] req1_hi, req1_lo;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [6:0]  rsp0_result, rsp1_result;

  // Second instance with fixed priority, its own request/response signals.
  logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic        f_rsp0_valid, f_rsp1_valid, f_rsp0_ready, f_rsp1_ready;
  logic [6:0]  f_rsp0_result, f_rsp1_result;
  logic [31:0] f_lo;

  int total = 0;
  int bad   = 0;

  antares_cloz_scheduler #(.PRIO_FIXED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_wide(req0_wide), .req0_hi(req0_hi), .req0_lo(req0_lo),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_wide(req1_wide), .req1_hi(req1_hi), .req1_lo(req1_lo),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result)
  );

  antares_cloz_scheduler #(.PRIO_FIXED(1'b1)) u_dut_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op(1'b0),
    .req0_wide(1'b0), .req0_hi(32'h0), .req0_lo(f_lo),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_op(1'b1),
    .req1_wide(1'b0), .req1_hi(32'h0), .req1_lo(f_lo),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp0_result(f_rsp0_result),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready), .rsp1_result(f_rsp1_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A request seen unaccepted at an edge must still be valid at the next edge.
  logic pend0, pend1;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (pend0 && !req0_valid) begin
        bad++;
        $display("FAIL req0_valid_dropped: valid=0 required=1");
      end
      if (pend1 && !req1_valid) begin
        bad++;
        $display("FAIL req1_valid_dropped: valid=0 required=1");
      end
      pend0 <= req0_valid && !req0_ready;
      pend1 <= req1_valid && !req1_ready;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one op on a port and measure accept-to-rsp_valid latency in cycles.
  task automatic do_op(input int port, input logic op, input logic wide,
                       input logic [31:0] hi, input logic [31:0] lo,
                       output logic [6:0] res, output int lat, output logic other_v);
    logic acc, v;
    int   n;
    if (port == 0) begin
      req0_op = op; req0_wide = wide; req0_hi = hi; req0_lo = lo;
      req0_valid = 1'b1; rsp0_ready = 1'b1;
    end else begin
      req1_op = op; req1_wide = wide; req1_hi = hi; req1_lo = lo;
      req1_valid = 1'b1; rsp1_ready = 1'b1;
    end
    #1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = (port == 0) ? req0_ready : req1_ready;
      if (!acc) begin @(negedge clk); #1; end
    end
    res = '0; lat = -1; other_v = 1'b0; v = 1'b0; n = 0;
    if (acc) begin
      do begin
        @(negedge clk);
        if (n == 0) begin
          if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
        #1;
        n++;
        v = (port == 0) ? rsp0_valid : rsp1_valid;
        if ((port == 0) ? rsp1_valid : rsp0_valid) other_v = 1'b1;
      end while (!v && n < 10);
      if (v) lat = n;
      res = (port == 0) ? rsp0_result : rsp1_result;
    end else begin
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // Let pending requests complete, dropping each valid after its handshake.
  task automatic drain();
    logic d0, d1;
    d0 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req0_valid && req0_ready) d0 = 1'b1;
      if (req1_valid && req1_ready) d1 = 1'b1;
      @(negedge clk);
      if (d0) begin req0_valid = 1'b0; d0 = 1'b0; end
      if (d1) begin req1_valid = 1'b0; d1 = 1'b0; end
      #1;
    end
  endtask

  typedef struct {
    int          port;
    logic        op;
    logic        wide;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [6:0]  exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [6:0] res;
    int         lat, c0, c1, ng;
    logic       ov, got;
    int         gport[4];
    int         gcyc[4];

    vecs[0]  = '{0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_8000, 7'd16, 2};
    vecs[1]  = '{1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hF000_0000, 7'd36, 3};
    vecs[2]  = '{0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 7'd64, 3};
    vecs[3]  = '{1, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 7'd32, 2};
    vecs[4]  = '{0, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000, 7'd0,  2};
    vecs[5]  = '{1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 7'd0,  2};
    vecs[6]  = '{0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001, 7'd31, 2};
    vecs[7]  = '{1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd64, 3};
    vecs[8]  = '{0, 1'b0, 1'b1, 32'h0000_0000, 32'h0001_0000, 7'd47, 3};
    vecs[9]  = '{1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 7'd32, 2};
    vecs[10] = '{0, 1'b1, 1'b1, 32'hFFFF_0000, 32'hFFFF_FFFF, 7'd16, 2};

    rst_n = 1'b0;
    req0_valid = 0; req0_op = 0; req0_wide = 0; req0_hi = 0; req0_lo = 0;
    req1_valid = 0; req1_op = 0; req1_wide = 0; req1_hi = 0; req1_lo = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    f_req0_valid = 0; f_req1_valid = 0; f_rsp0_ready = 1; f_rsp1_ready = 1;
    f_lo = 32'h0000_00FF;

    // Reset state: ready held low even with requests present.
    repeat (2) @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_result", rsp1_result, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].port, vecs[i].op, vecs[i].wide, vecs[i].hi, vecs[i].lo, res, lat, ov);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_other_rsp", i), ov, 0);
    end

    // Round-robin: pointer reinitialised by reset, so port 0 goes first.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    req0_op = 0; req0_wide = 0; req0_lo = 32'h1;
    req1_op = 0; req1_wide = 0; req1_lo = 32'h100;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      if (req0_valid && req0_ready) begin gport[ng] = 0; gcyc[ng] = cyc; ng++; end
      else if (req1_valid && req1_ready) begin gport[ng] = 1; gcyc[ng] = cyc; ng++; end
      if (ng < 4) begin @(negedge clk); #1; end
    end
    chk("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d_port", i), (i < ng) ? gport[i] : -1, i % 2);
      if (i > 0) chk($sformatf("rr_gap%0d", i), (i < ng) ? gcyc[i] - gcyc[i-1] : -1, 3);
    end
    drain();

    // Back-pressure on port 0 while port 1 waits.
    rsp0_ready = 0;
    req0_op = 0; req0_wide = 0; req0_lo = 32'h0000_0F00;
    req0_valid = 1;
    #1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      got = req0_ready;
      if (!got) begin @(negedge clk); #1; end
    end
    chk("stall_accept0", got, 1);
    @(negedge clk);
    req0_valid = 0;
    req1_op = 1; req1_wide = 0; req1_lo = 32'hC000_0000; req1_valid = 1; rsp1_ready = 1;
    #1;
    for (int i = 0; i < 10 && !rsp0_valid; i++) begin @(negedge clk); #1; end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall%0d_rsp0_valid", k), rsp0_valid, 1);
      chk($sformatf("stall%0d_rsp0_result", k), rsp0_result, 20);
      chk($sformatf("stall%0d_req1_ready", k), req1_ready, 0);
      @(negedge clk); #1;
    end
    rsp0_ready = 1;
    @(negedge clk); #1;
    chk("release_rsp0_valid", rsp0_valid, 0);
    chk("release_req1_ready", req1_ready, 1);
    drain();

    // Reset during the second pass of a wide op.
    req0_op = 0; req0_wide = 1; req0_hi = 32'h0; req0_lo = 32'h0; req0_valid = 1;
    #1;
    chk("midrst_accept0", req0_ready, 1);
    @(negedge clk); req0_valid = 0;
    @(negedge clk);
    rst_n = 1'b0;
    req0_wide = 0; req0_lo = 32'h0000_FFFF; req0_valid = 1;
    req1_wide = 0; req1_lo = 32'h0000_00FF; req1_valid = 1;
    #1;
    chk("midrst_rsp0_valid", rsp0_valid, 0);
    chk("midrst_rsp0_result", rsp0_result, 0);
    chk("midrst_req0_ready", req0_ready, 0);
    chk("midrst_req1_ready", req1_ready, 0);
    @(negedge clk); #1;
    chk("midrst_hold_rsp0_valid", rsp0_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("postrst_req0_ready", req0_ready, 1);
    chk("postrst_req1_ready", req1_ready, 0);
    chk("postrst_rsp0_valid", rsp0_valid, 0);
    drain();

    // Fixed priority: port 1 starves while port 0 stays valid.
    f_req0_valid = 1; f_req1_valid = 1;
    #1;
    c0 = 0; c1 = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (f_req0_ready) c0++;
      if (f_req1_ready) c1++;
      @(negedge clk); #1;
    end
    chk("fixed_port0_grants", c0, 10);
    chk("fixed_port1_grants", c1, 0);
    for (int i = 0; i < 6 && !f_req0_ready; i++) begin @(negedge clk); #1; end
    @(negedge clk); f_req0_valid = 0;
    #1;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      got = f_req1_ready;
      if (!got) begin @(negedge clk); #1; end
    end
    chk("fixed_port1_after_release", got, 1);
    @(negedge clk); f_req1_valid = 0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
